// File: rtl/outr_tx.sv
// outr_tx: OUTR output register with 8N1 serial transmitter and FGO/interrupt flag
// Ports: CLK/CLR clock and async active-high reset; AC_LOW byte source; OUT_LD load strobe;
//        IEN interrupt enable; OUTR register; FGO ready flag; BUSY frame active; TXD serial line;
//        INT_OUT = FGO & IEN.
module outr_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] AC_LOW,
  input  logic       OUT_LD,
  input  logic       IEN,
  output logic [7:0] OUTR,
  output logic       FGO,
  output logic       BUSY,
  output logic       TXD,
  output logic       INT_OUT
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q;
  logic [7:0]    outr_q;
  logic          fgo_q;
  logic          txd_q;
  logic [2:0]    bit_q;
  logic [BW-1:0] baud_q;
  logic          bit_end;
  assign bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
  // TXD is loaded one edge ahead of each bit so the line comes straight from a flop.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      outr_q  <= 8'h00;
      fgo_q   <= 1'b1;
      txd_q   <= 1'b1;
      bit_q   <= 3'd0;
      baud_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (OUT_LD && fgo_q) begin
          outr_q  <= AC_LOW;
          fgo_q   <= 1'b0;
          baud_q  <= '0;
          txd_q   <= 1'b0;
          state_q <= START;
        end
        START: begin
          baud_q <= bit_end ? '0 : baud_q + 1'b1;
          if (bit_end) begin
            bit_q   <= 3'd0;
            txd_q   <= outr_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          baud_q <= bit_end ? '0 : baud_q + 1'b1;
          if (bit_end) begin
            bit_q   <= bit_q + 3'd1;
            txd_q   <= bit_q == 3'd7 ? 1'b1 : outr_q[bit_q + 3'd1];
            state_q <= bit_q == 3'd7 ? STOP : DATA;
          end
        end
        STOP: begin
          baud_q <= bit_end ? '0 : baud_q + 1'b1;
          if (bit_end) begin
            fgo_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign OUTR    = outr_q;
  assign FGO     = fgo_q;
  assign BUSY    = state_q != IDLE;
  assign TXD     = txd_q;
  assign INT_OUT = fgo_q & IEN;
endmodule

// File: tb/tb_outr_tx.sv
// tb_outr_tx: directed self-checking bench for outr_tx with four clocks per bit
module tb_outr_tx;
  localparam int N = 4;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] ac = 8'h00;
  logic       ld = 1'b0;
  logic       ien = 1'b0;
  logic [7:0] outr;
  logic       fgo, busy, txd, int_out;
  int checks = 0;
  int errors = 0;

  outr_tx #(.CLKS_PER_BIT(N)) dut (
    .CLK(clk), .CLR(clr), .AC_LOW(ac), .OUT_LD(ld), .IEN(ien),
    .OUTR(outr), .FGO(fgo), .BUSY(busy), .TXD(txd), .INT_OUT(int_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input int s, input logic [7:0] b);
    return s == 0 ? 1'b0 : s == 9 ? 1'b1 : b[s-1];
  endfunction

  task automatic test_reset;
    ien = 1'b1;
    tick();
    tick();
    checks++; if (outr !== 8'h00) begin errors++; $display("FAIL reset_outr got %h exp 00", outr); end
    checks++; if (fgo !== 1'b1) begin errors++; $display("FAIL reset_fgo got %b exp 1", fgo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL reset_int_ien1 got %b exp 1", int_out); end
    ien = 1'b0;
    #1;
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int_ien0 got %b exp 0", int_out); end
    clr = 1'b0;
    tick();
    checks++; if (fgo !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset fgo %b busy %b exp 1 0", fgo, busy); end
  endtask

  task automatic test_single_frame;
    ac = 8'hA5; ld = 1'b1;
    tick();
    ld = 1'b0; ac = 8'h00;
    for (int c = 0; c < 10*N; c++) begin
      checks++; if (txd !== fbit(c/N, 8'hA5)) begin errors++; $display("FAIL frame_txd c=%0d got %b exp %b", c, txd, fbit(c/N, 8'hA5)); end
      checks++; if (fgo !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL frame_fgo c=%0d fgo %b busy %b exp 0 1", c, fgo, busy); end
      checks++; if (outr !== 8'hA5) begin errors++; $display("FAIL frame_outr c=%0d got %h exp a5", c, outr); end
      tick();
    end
    checks++; if (fgo !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL frame_end fgo %b busy %b exp 1 0", fgo, busy); end
    checks++; if (outr !== 8'hA5 || txd !== 1'b1) begin errors++; $display("FAIL frame_hold outr %h txd %b exp a5 1", outr, txd); end
  endtask

  task automatic test_strobe_busy;
    ac = 8'hA5; ld = 1'b1;
    tick();
    ld = 1'b0;
    for (int c = 0; c < 10*N; c++) begin
      checks++; if (txd !== fbit(c/N, 8'hA5)) begin errors++; $display("FAIL busy_txd c=%0d got %b exp %b", c, txd, fbit(c/N, 8'hA5)); end
      checks++; if (outr !== 8'hA5) begin errors++; $display("FAIL busy_outr c=%0d got %h exp a5", c, outr); end
      ld = c == 11; ac = c == 11 ? 8'h3C : 8'h00;
      tick();
    end
    checks++; if (fgo !== 1'b1 || outr !== 8'hA5) begin errors++; $display("FAIL busy_end fgo %b outr %h exp 1 a5", fgo, outr); end
  endtask

  task automatic test_back_to_back;
    ac = 8'h01; ld = 1'b1;
    tick();
    ac = 8'h80;
    for (int c = 0; c < 10*N; c++) begin
      checks++; if (txd !== fbit(c/N, 8'h01)) begin errors++; $display("FAIL b2b_first_txd c=%0d got %b exp %b", c, txd, fbit(c/N, 8'h01)); end
      checks++; if (outr !== 8'h01) begin errors++; $display("FAIL b2b_first_outr c=%0d got %h exp 01", c, outr); end
      tick();
    end
    checks++; if (fgo !== 1'b1 || busy !== 1'b0 || outr !== 8'h01) begin errors++; $display("FAIL b2b_completion fgo %b busy %b outr %h exp 1 0 01", fgo, busy, outr); end
    tick();
    checks++; if (fgo !== 1'b0 || outr !== 8'h80) begin errors++; $display("FAIL b2b_accept fgo %b outr %h exp 0 80", fgo, outr); end
    ld = 1'b0;
    for (int c = 0; c < 10*N; c++) begin
      checks++; if (txd !== fbit(c/N, 8'h80)) begin errors++; $display("FAIL b2b_second_txd c=%0d got %b exp %b", c, txd, fbit(c/N, 8'h80)); end
      tick();
    end
    checks++; if (fgo !== 1'b1) begin errors++; $display("FAIL b2b_second_end fgo %b exp 1", fgo); end
  endtask

  task automatic test_reset_mid_frame;
    ac = 8'hFF; ld = 1'b1;
    tick();
    ld = 1'b0;
    for (int c = 0; c < 17; c++) tick();
    checks++; if (txd !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_bit3 txd %b busy %b exp 1 1", txd, busy); end
    #2 clr = 1'b1;
    #1;
    checks++; if (txd !== 1'b1 || fgo !== 1'b1) begin errors++; $display("FAIL abort_txd_fgo txd %b fgo %b exp 1 1", txd, fgo); end
    checks++; if (busy !== 1'b0 || outr !== 8'h00) begin errors++; $display("FAIL abort_busy_outr busy %b outr %h exp 0 00", busy, outr); end
    ac = 8'h55; ld = 1'b1;
    tick();
    checks++; if (fgo !== 1'b1 || outr !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL clr_priority fgo %b outr %h busy %b exp 1 00 0", fgo, outr, busy); end
    clr = 1'b0;
    tick();
    ld = 1'b0;
    for (int c = 0; c < 10*N; c++) begin
      checks++; if (txd !== fbit(c/N, 8'h55)) begin errors++; $display("FAIL fresh_txd c=%0d got %b exp %b", c, txd, fbit(c/N, 8'h55)); end
      checks++; if (fgo !== 1'b0 || outr !== 8'h55) begin errors++; $display("FAIL fresh_state c=%0d fgo %b outr %h exp 0 55", c, fgo, outr); end
      tick();
    end
    checks++; if (fgo !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fresh_end fgo %b busy %b exp 1 0", fgo, busy); end
  endtask

  task automatic test_interrupt;
    ien = 1'b1;
    #1;
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL int_idle got %b exp 1", int_out); end
    ac = 8'hC3; ld = 1'b1;
    tick();
    ld = 1'b0;
    for (int c = 0; c < 10*N; c++) begin
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL int_busy c=%0d got %b exp 0", c, int_out); end
      tick();
    end
    checks++; if (int_out !== 1'b1 || fgo !== 1'b1) begin errors++; $display("FAIL int_return int %b fgo %b exp 1 1", int_out, fgo); end
    ien = 1'b0;
    ac = 8'h3C; ld = 1'b1;
    tick();
    ld = 1'b0;
    for (int c = 0; c < 10*N + 2; c++) begin
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL int_disabled c=%0d got %b exp 0", c, int_out); end
      tick();
    end
    checks++; if (fgo !== 1'b1) begin errors++; $display("FAIL int_disabled_end fgo %b exp 1", fgo); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    tick();
    test_strobe_busy();
    tick();
    test_back_to_back();
    tick();
    test_reset_mid_frame();
    tick();
    test_interrupt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
